// File: rtl/stage5_field_extract_module_if.sv
// Handshake and data bundle for the stage-5 field extractor.
// Master drives message sets and the downstream ready; slave is the extractor.
interface stage5_field_extract_module_if #(
  parameter int unsigned N_CH       = 3,
  parameter int unsigned MSG_BITS   = 256,
  parameter int unsigned FIELD_BITS = 32,
  parameter int unsigned MUX_W      = 4,
  parameter int unsigned CNT_W      = 16
);

  logic                       in_valid;
  logic                       in_ready;
  logic [N_CH*MSG_BITS-1:0]   message;
  logic [N_CH*MUX_W-1:0]      mux_ctrl;
  logic                       out_valid;
  logic                       out_ready;
  logic [N_CH*FIELD_BITS-1:0] field;
  logic [N_CH-1:0]            field_hit;
  logic                       cnt_clr;
  logic [N_CH*CNT_W-1:0]      hit_cnt;

  modport master (
    output in_valid,
    output message,
    output mux_ctrl,
    output out_ready,
    output cnt_clr,
    input  in_ready,
    input  out_valid,
    input  field,
    input  field_hit,
    input  hit_cnt
  );

  modport slave (
    input  in_valid,
    input  message,
    input  mux_ctrl,
    input  out_ready,
    input  cnt_clr,
    output in_ready,
    output out_valid,
    output field,
    output field_hit,
    output hit_cnt
  );

endinterface

// File: rtl/stage5_field_extract_module.sv
// Extracts one field per message channel behind a valid/ready handshake,
// buffered in a 2-entry FIFO, with saturating per-channel hit counters.
module stage5_field_extract_module #(
  parameter int unsigned           N_CH        = 3,
  parameter int unsigned           MSG_BITS    = 256,
  parameter int unsigned           FIELD_LSB   = 64,
  parameter int unsigned           FIELD_BITS  = 32,
  parameter int unsigned           MUX_W       = 4,
  parameter logic [MUX_W-1:0]      MUX_SEL     = 4'h1,
  parameter logic [FIELD_BITS-1:0] DEFAULT_VAL = '0,
  parameter int unsigned           CNT_W       = 16
) (
  input logic                          clk,
  input logic                          rst_n,
  stage5_field_extract_module_if.slave bus
);

  localparam logic [N_CH*FIELD_BITS-1:0] FieldReset = {N_CH{DEFAULT_VAL}};

  logic [1:0]                 count_q, count_d;
  logic [N_CH*FIELD_BITS-1:0] head_field_q, head_field_d;
  logic [N_CH*FIELD_BITS-1:0] tail_field_q, tail_field_d;
  logic [N_CH-1:0]            head_hit_q, head_hit_d;
  logic [N_CH-1:0]            tail_hit_q, tail_hit_d;
  logic [N_CH*CNT_W-1:0]      hit_cnt_q, hit_cnt_d;

  logic [N_CH*FIELD_BITS-1:0] new_field;
  logic [N_CH-1:0]            new_hit;
  logic                       push, pop;

  // Ready depends only on the registered occupancy, never on out_ready.
  assign bus.in_ready  = (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  assign bus.field     = head_field_q;
  assign bus.field_hit = bus.out_valid ? head_hit_q : '0;
  assign bus.hit_cnt   = hit_cnt_q;

  always_comb begin
    new_field = '0;
    new_hit   = '0;
    for (int c = 0; c < N_CH; c++) begin
      new_hit[c] = (bus.mux_ctrl[c*MUX_W +: MUX_W] == MUX_SEL);
      new_field[c*FIELD_BITS +: FIELD_BITS] =
          new_hit[c] ? bus.message[c*MSG_BITS + FIELD_LSB +: FIELD_BITS] : DEFAULT_VAL;
    end
  end

  // Head is only overwritten by a real entry, so field holds its last value once drained.
  always_comb begin
    count_d      = count_q;
    head_field_d = head_field_q;
    head_hit_d   = head_hit_q;
    tail_field_d = tail_field_q;
    tail_hit_d   = tail_hit_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_field_d = new_field;
          head_hit_d   = new_hit;
        end else begin
          tail_field_d = new_field;
          tail_hit_d   = new_hit;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) begin
          head_field_d = tail_field_q;
          head_hit_d   = tail_hit_q;
        end
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Only reachable with one entry: the new set replaces the departing head.
        head_field_d = new_field;
        head_hit_d   = new_hit;
      end
      default: ;
    endcase
  end

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    for (int c = 0; c < N_CH; c++) begin
      if (bus.cnt_clr) begin
        hit_cnt_d[c*CNT_W +: CNT_W] = '0;
      end else if (push && new_hit[c] && (hit_cnt_q[c*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
        hit_cnt_d[c*CNT_W +: CNT_W] = hit_cnt_q[c*CNT_W +: CNT_W] + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= 2'd0;
      head_field_q <= FieldReset;
      head_hit_q   <= '0;
      tail_field_q <= FieldReset;
      tail_hit_q   <= '0;
      hit_cnt_q    <= '0;
    end else begin
      count_q      <= count_d;
      head_field_q <= head_field_d;
      head_hit_q   <= head_hit_d;
      tail_field_q <= tail_field_d;
      tail_hit_q   <= tail_hit_d;
      hit_cnt_q    <= hit_cnt_d;
    end
  end

endmodule

// File: tb/tb_stage5_field_extract_module.sv
// Directed bench for stage5_field_extract_module: a queue of expected field sets
// is pushed on every accept and popped when the block hands a set downstream.
module tb_stage5_field_extract_module;

  localparam int unsigned           N_CH        = 3;
  localparam int unsigned           MSG_BITS    = 256;
  localparam int unsigned           FIELD_LSB   = 64;
  localparam int unsigned           FIELD_BITS  = 32;
  localparam int unsigned           MUX_W       = 4;
  localparam logic [MUX_W-1:0]      MUX_SEL     = 4'h1;
  localparam logic [FIELD_BITS-1:0] DEFAULT_VAL = '0;
  localparam int unsigned           CNT_W       = 4;

  typedef struct packed {
    logic [N_CH*FIELD_BITS-1:0] f;
    logic [N_CH-1:0]            h;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stage5_field_extract_module_if #(
    .N_CH(N_CH), .MSG_BITS(MSG_BITS), .FIELD_BITS(FIELD_BITS), .MUX_W(MUX_W), .CNT_W(CNT_W)
  ) bus ();

  stage5_field_extract_module #(
    .N_CH(N_CH), .MSG_BITS(MSG_BITS), .FIELD_LSB(FIELD_LSB), .FIELD_BITS(FIELD_BITS),
    .MUX_W(MUX_W), .MUX_SEL(MUX_SEL), .DEFAULT_VAL(DEFAULT_VAL), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t                       sb[$];
  int unsigned                n_checks = 0;
  int unsigned                n_fails  = 0;
  logic [CNT_W-1:0]           cnt_m[N_CH];
  logic [N_CH*FIELD_BITS-1:0] last_field;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_chan(input int c, input logic [MUX_W-1:0] ctrl,
                          input logic [FIELD_BITS-1:0] v);
    for (int w = 0; w < MSG_BITS / 32; w++) bus.message[c*MSG_BITS + w*32 +: 32] = $urandom;
    bus.message[c*MSG_BITS + FIELD_LSB +: FIELD_BITS] = v;
    bus.mux_ctrl[c*MUX_W +: MUX_W] = ctrl;
  endtask

  task automatic rand_set();
    for (int c = 0; c < N_CH; c++) set_chan(c, MUX_W'($urandom_range(0, 2)), $urandom);
  endtask

  // One clock: check outputs at the falling edge, advance the model, return after the edge.
  task automatic cycle(output logic acc);
    exp_t e;
    logic push, pop;
    @(negedge clk);
    chk("in_ready", bus.in_ready, sb.size() < 2);
    chk("out_valid", bus.out_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      chk("field", bus.field, sb[0].f);
      chk("field_hit", bus.field_hit, sb[0].h);
    end else begin
      chk("idle_field", bus.field, last_field);
      chk("idle_field_hit", bus.field_hit, 0);
    end
    for (int c = 0; c < N_CH; c++) chk("hit_cnt", bus.hit_cnt[c*CNT_W +: CNT_W], cnt_m[c]);
    pop  = (sb.size() != 0) && bus.out_ready;
    push = bus.in_valid && (sb.size() < 2);
    for (int c = 0; c < N_CH; c++) begin
      e.h[c] = (bus.mux_ctrl[c*MUX_W +: MUX_W] == MUX_SEL);
      e.f[c*FIELD_BITS +: FIELD_BITS] =
          e.h[c] ? bus.message[c*MSG_BITS + FIELD_LSB +: FIELD_BITS] : DEFAULT_VAL;
    end
    if (pop) begin
      last_field = sb[0].f;
      void'(sb.pop_front());
    end
    if (push) sb.push_back(e);
    for (int c = 0; c < N_CH; c++) begin
      if (bus.cnt_clr) cnt_m[c] = '0;
      else if (push && e.h[c] && cnt_m[c] != {CNT_W{1'b1}}) cnt_m[c] = cnt_m[c] + 1'b1;
    end
    acc = push;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc;
    int   k;
    int   early;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.cnt_clr   = 1'b0;
    bus.message   = '0;
    bus.mux_ctrl  = '0;
    for (int c = 0; c < N_CH; c++) cnt_m[c] = '0;
    last_field = {N_CH{DEFAULT_VAL}};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_field", bus.field, 0);
    chk("rst_field_hit", bus.field_hit, 0);
    chk("rst_hit_cnt", bus.hit_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic select on all channels.
    set_chan(0, 4'h1, 32'hA1B2C3D4);
    set_chan(1, 4'h1, 32'h11111111);
    set_chan(2, 4'h1, 32'hDEADBEEF);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    cycle(acc);
    bus.in_valid = 1'b0;
    cycle(acc);
    chk("basic_hit_cnt", bus.hit_cnt, 12'h111);

    // Mixed select: only channel 0 matches.
    set_chan(0, 4'h1, 32'h0BADF00D);
    set_chan(1, 4'h0, 32'h12345678);
    set_chan(2, 4'h2, 32'h87654321);
    bus.in_valid = 1'b1;
    cycle(acc);
    bus.in_valid = 1'b0;
    cycle(acc);
    chk("mixed_hit_cnt", bus.hit_cnt, 12'h112);

    // Backpressure: four sets, each held until accepted; out_ready released after 4 cycles.
    bus.out_ready = 1'b0;
    rand_set();
    bus.in_valid = 1'b1;
    k     = 0;
    early = 0;
    for (int n = 0; n < 16 && k < 4; n++) begin
      if (n == 4) bus.out_ready = 1'b1;
      cycle(acc);
      if (acc) begin
        k++;
        if (n < 4) early++;
        rand_set();
      end
    end
    chk("bp_total_accepts", k, 4);
    chk("bp_accepts_while_stalled", early, 2);
    bus.in_valid = 1'b0;
    repeat (2) cycle(acc);

    // Streaming: one set per cycle with downstream always ready.
    bus.in_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      rand_set();
      cycle(acc);
      chk("stream_accept", acc, 1);
    end
    bus.in_valid = 1'b0;
    repeat (2) cycle(acc);

    // Saturation and clear priority on channel 0.
    set_chan(0, 4'h1, 32'hCAFE0000);
    set_chan(1, 4'h3, 32'h0);
    set_chan(2, 4'h3, 32'h0);
    bus.in_valid = 1'b1;
    repeat (20) cycle(acc);
    chk("sat_cnt0", bus.hit_cnt[CNT_W-1:0], 15);
    bus.cnt_clr = 1'b1;
    cycle(acc);
    chk("clr_cnt0", bus.hit_cnt[CNT_W-1:0], 0);
    bus.cnt_clr  = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) cycle(acc);

    // Asynchronous reset with both entries occupied.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    rand_set();
    set_chan(0, 4'h1, 32'h55AA55AA);
    cycle(acc);
    rand_set();
    set_chan(0, 4'h1, 32'hAA55AA55);
    cycle(acc);
    chk("pre_rst_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_field", bus.field, 0);
    chk("arst_field_hit", bus.field_hit, 0);
    chk("arst_hit_cnt", bus.hit_cnt, 0);
    sb.delete();
    for (int c = 0; c < N_CH; c++) cnt_m[c] = '0;
    last_field = {N_CH{DEFAULT_VAL}};
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) cycle(acc);
    rand_set();
    bus.in_valid = 1'b1;
    cycle(acc);
    bus.in_valid = 1'b0;
    repeat (2) cycle(acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/stage5_field_extract_module.md
Name: stage5_field_extract_module

Overview:
- Parametrised, registered successor to the stage-5 single-field extractors.
- Pulls one configurable field from each of N_CH message channels. A channel is selected when its mux control equals MUX_SEL; otherwise the channel outputs DEFAULT_VAL.
- Adds a valid/ready handshake with a 2-entry output buffer and per-channel saturating hit counters.
- Sits between the stage-4 message mux and the stage-6 field consumers.

Parameters:
- N_CH, 3, number of message channels.
- MSG_BITS, 256, width of each message.
- FIELD_LSB, 64, bit offset of the field LSB within a message.
- FIELD_BITS, 32, field width; FIELD_LSB+FIELD_BITS <= MSG_BITS.
- MUX_W, 4, width of each channel's mux control.
- MUX_SEL, 4'h1, control value that selects the field.
- DEFAULT_VAL, 0, FIELD_BITS-wide value output on no-select.
- CNT_W, 16, hit-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  message set valid (replaces message_en).
- in_ready  out  1  block can accept a message set.
- message  in  N_CH*MSG_BITS  channel c occupies [c*MSG_BITS +: MSG_BITS].
- mux_ctrl  in  N_CH*MUX_W  channel c occupies [c*MUX_W +: MUX_W].
- out_valid  out  1  field set valid.
- out_ready  in  1  downstream accepts field set.
- field  out  N_CH*FIELD_BITS  channel c occupies [c*FIELD_BITS +: FIELD_BITS].
- field_hit  out  N_CH  per-channel select flag, aligned with field.
- cnt_clr  in  1  synchronous clear of hit counters.
- hit_cnt  out  N_CH*CNT_W  per-channel hit counters.

Behaviour:
- Reset (rst_n low, asynchronous): buffer emptied, out_valid=0, field=DEFAULT_VAL on every channel, field_hit=0, hit_cnt=0. in_ready=1 from the first cycle after release.
- Accept: an accept occurs when in_valid && in_ready at a rising edge.
- Per-channel result on accept:
  - hit_c = (mux_ctrl_c == MUX_SEL).
  - field_c = hit_c ? message_c[FIELD_LSB +: FIELD_BITS] : DEFAULT_VAL.
- Buffer: 2-entry FIFO of {field, field_hit}, with count in 0..2.
  - in_ready = (count < 2), driven purely from registered state, with no combinational path from out_ready.
  - out_valid = (count != 0). field and field_hit present the head entry.
  - Pop occurs when out_valid && out_ready.
- Latency: an accepted set appears at out_valid on the next cycle if the buffer was empty. Throughput is 1 set/cycle while out_ready=1.
- Simultaneous push and pop:
  - count=1: count stays 1 and the head is replaced by the new set.
  - count=2: no push (in_ready=0); pop only.
- Ordering: strict FIFO. Output holds stable while out_valid && !out_ready.
- When out_valid=0: field holds its last value, and field_hit=0.
- Hit counters: on each accept, hit_cnt_c increments for every channel with hit_c=1. Counters saturate at 2^CNT_W-1 with no wrap.
  - cnt_clr=1 forces all counters to 0 and wins over a same-cycle increment.
  - Counters are unaffected by out_ready.
- in_valid=0 leaves buffer and counters unchanged. message and mux_ctrl are don't-care when no accept occurs.
- Reset mid-operation: buffered entries are discarded; no partial output.

Test Plan:
- Basic select. N_CH=3, mux_ctrl={1,1,1}, channel messages carry 0xA1B2C3D4 / 0x11111111 / 0xDEADBEEF at bits [95:64], one accept, out_ready=1 -> next cycle out_valid=1, field = those three values, field_hit=3'b111, hit_cnt={1,1,1}.
- Mixed select. mux_ctrl={1,0,2} (channels 0,1,2) -> field0=message field, field1=field2=0, field_hit=3'b001; only hit_cnt0 increments.
- Backpressure. out_ready=0, in_valid=1 for 4 cycles with distinct sets S0..S3 -> in_ready drops after 2 accepts. Release out_ready -> outputs S0 then S1, in order. S2 and S3 are accepted only once in_ready is high again.
- Streaming. in_valid=1 and out_ready=1 for 10 cycles -> 10 outputs, one per cycle, starting 1 cycle after the first accept; count never exceeds 1.
- Saturation/clear. CNT_W=4, 20 hitting accepts on channel 0 -> hit_cnt0=15. cnt_clr together with a hitting accept -> hit_cnt0=0.
- Async reset. Assert rst_n=0 mid-cycle while count=2 -> out_valid=0, field=0 and hit_cnt=0 immediately. After release, in_ready=1 and no stale output appears.
